// File: rtl/sram_mem_target.sv
// sram_mem_target: mem_* bus responder backed by an async 16-bit SRAM.
// Each 32-bit word moves as up to two halfword accesses with wait states.
module sram_mem_target #(
   parameter int ADDR_WIDTH  = 20,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  cpu_clk2,
   input  logic                  rst,
   input  logic [29:0]           mem_address,
   input  logic [31:0]           mem_wr_data,
   input  logic [3:0]            mem_wr_mask,
   input  logic                  mem_wr_enable,
   output logic                  mem_wr_ack,
   input  logic                  mem_rd_enable,
   output logic [31:0]           mem_rd_data,
   output logic                  mem_rd_valid,
   output logic [ADDR_WIDTH-1:0] sram_a,
   inout  wire  [15:0]           sram_dq,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_ub_n,
   output logic                  sram_lb_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_RESP
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t state, state_nxt;

   logic [ADDR_WIDTH-2:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            mask_q;
   logic                  op_wr_q;
   logic                  half_q;
   logic                  need_hi_q;
   logic [3:0]            cnt_q;
   logic [15:0]           rd_lo_q;
   logic                  rd_armed;
   logic                  wr_armed;
   logic                  dq_oe;
   logic [15:0]           dq_out;

   logic accept_wr, accept_rd, lo_en, hi_en;
   logic unused_addr;

   assign unused_addr = ^mem_address[29:ADDR_WIDTH-1];

   assign accept_wr = mem_wr_enable & wr_armed;
   assign accept_rd = mem_rd_enable & rd_armed & ~accept_wr;
   assign lo_en     = |mem_wr_mask[1:0];
   assign hi_en     = |mem_wr_mask[3:2];

   always_ff @(posedge cpu_clk2 or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept_wr)
               state_nxt = (lo_en | hi_en) ? S_SETUP : S_RESP;
            else if (accept_rd)
               state_nxt = S_SETUP;
         end
         S_SETUP:  state_nxt = S_STROBE;
         S_STROBE: if (cnt_q == 4'd0) state_nxt = S_HOLD;
         S_HOLD:
            state_nxt = (!half_q && need_hi_q) ? S_SETUP : S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Low half is parked in rd_lo_q so mem_rd_data only changes
   // once the whole word has been read.
   always_ff @(posedge cpu_clk2 or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         op_wr_q     <= 1'b0;
         half_q      <= 1'b0;
         need_hi_q   <= 1'b0;
         cnt_q       <= '0;
         rd_lo_q     <= '0;
         mem_rd_data <= '0;
         rd_armed    <= 1'b1;
         wr_armed    <= 1'b1;
      end else begin
         if (!mem_wr_enable) wr_armed <= 1'b1;
         if (!mem_rd_enable) rd_armed <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (accept_wr) begin
                  wr_armed  <= 1'b0;
                  op_wr_q   <= 1'b1;
                  addr_q    <= mem_address[ADDR_WIDTH-2:0];
                  wdata_q   <= mem_wr_data;
                  mask_q    <= mem_wr_mask;
                  half_q    <= ~lo_en;
                  need_hi_q <= lo_en & hi_en;
               end else if (accept_rd) begin
                  rd_armed  <= 1'b0;
                  op_wr_q   <= 1'b0;
                  addr_q    <= mem_address[ADDR_WIDTH-2:0];
                  half_q    <= 1'b0;
                  need_hi_q <= 1'b1;
               end
            end
            S_SETUP: cnt_q <= WAIT_LD;
            S_STROBE: begin
               if (cnt_q != 4'd0)
                  cnt_q <= cnt_q - 4'd1;
               else if (!op_wr_q) begin
                  if (half_q) mem_rd_data <= {sram_dq, rd_lo_q};
                  else        rd_lo_q     <= sram_dq;
               end
            end
            S_HOLD: if (!half_q && need_hi_q) half_q <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_ub_n    = 1'b1;
      sram_lb_n    = 1'b1;
      sram_a       = '0;
      dq_oe        = 1'b0;
      mem_wr_ack   = 1'b0;
      mem_rd_valid = 1'b0;
      unique case (state)
         S_SETUP, S_STROBE, S_HOLD: begin
            sram_ce_n = 1'b0;
            sram_a    = {addr_q, half_q};
            if (op_wr_q) begin
               dq_oe     = 1'b1;
               sram_we_n = (state != S_STROBE);
               sram_lb_n = half_q ? ~mask_q[2] : ~mask_q[0];
               sram_ub_n = half_q ? ~mask_q[3] : ~mask_q[1];
            end else begin
               sram_oe_n = (state == S_HOLD);
               sram_lb_n = 1'b0;
               sram_ub_n = 1'b0;
            end
         end
         S_RESP: begin
            mem_wr_ack   = op_wr_q;
            mem_rd_valid = ~op_wr_q;
         end
         default: ;
      endcase
   end

   assign dq_out  = half_q ? wdata_q[31:16] : wdata_q[15:0];
   assign sram_dq = dq_oe ? dq_out : 16'bz;

endmodule

// File: tb/tb_sram_mem_target.sv
// tb_sram_mem_target: directed and random checks of sram_mem_target
// against a word-level reference model and a behavioural SRAM.
module tb_sram_mem_target;

   localparam int AW = 20;
   localparam int WC = 2;

   logic          cpu_clk2 = 1'b0;
   logic          rst = 1'b1;
   logic [29:0]   mem_address = '0;
   logic [31:0]   mem_wr_data = '0;
   logic [3:0]    mem_wr_mask = '0;
   logic          mem_wr_enable = 1'b0;
   logic          mem_wr_ack;
   logic          mem_rd_enable = 1'b0;
   logic [31:0]   mem_rd_data;
   logic          mem_rd_valid;
   logic [AW-1:0] sram_a;
   wire  [15:0]   sram_dq;
   logic          sram_ce_n, sram_oe_n, sram_we_n;
   logic          sram_ub_n, sram_lb_n;

   int errors = 0;
   int checks = 0;
   logic last_ub, last_lb;

   sram_mem_target #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
      .cpu_clk2      (cpu_clk2),
      .rst           (rst),
      .mem_address   (mem_address),
      .mem_wr_data   (mem_wr_data),
      .mem_wr_mask   (mem_wr_mask),
      .mem_wr_enable (mem_wr_enable),
      .mem_wr_ack    (mem_wr_ack),
      .mem_rd_enable (mem_rd_enable),
      .mem_rd_data   (mem_rd_data),
      .mem_rd_valid  (mem_rd_valid),
      .sram_a        (sram_a),
      .sram_dq       (sram_dq),
      .sram_ce_n     (sram_ce_n),
      .sram_oe_n     (sram_oe_n),
      .sram_we_n     (sram_we_n),
      .sram_ub_n     (sram_ub_n),
      .sram_lb_n     (sram_lb_n)
   );

   always #5 cpu_clk2 = ~cpu_clk2;

   // Behavioural async SRAM; unwritten cells read a fixed pattern.
   logic [15:0] sram     [0:(1<<AW)-1];
   bit          sram_vld [0:(1<<AW)-1];

   function automatic logic [15:0] init_hw(input int a);
      logic [31:0] t;
      t = (a * 32'd40503) ^ 32'h5A5A;
      return t[15:0];
   endfunction

   function automatic logic [15:0] hw_rd(input int a);
      return sram_vld[a] ? sram[a] : init_hw(a);
   endfunction

   logic        sram_rd_on;
   logic [15:0] sram_rd_val;
   logic [15:0] cur_hw;
   assign sram_rd_on  = !sram_ce_n && !sram_oe_n && sram_we_n;
   assign sram_rd_val = hw_rd(int'(sram_a));
   assign sram_dq     = sram_rd_on ? sram_rd_val : 16'bz;

   always @(posedge sram_we_n) begin
      if (!sram_ce_n) begin
         cur_hw = hw_rd(int'(sram_a));
         sram[sram_a] <= {sram_ub_n ? cur_hw[15:8] : sram_dq[15:8],
                          sram_lb_n ? cur_hw[7:0]  : sram_dq[7:0]};
         sram_vld[sram_a] <= 1'b1;
      end
   end

   // Word-level reference model
   logic [31:0] ref_w [int];

   function automatic logic [31:0] exp_word(input int k);
      if (ref_w.exists(k)) return ref_w[k];
      return {init_hw(2*k+1), init_hw(2*k)};
   endfunction

   task automatic ref_write(input int k, input logic [31:0] d,
                            input logic [3:0] m);
      logic [31:0] w;
      w = exp_word(k);
      for (int b = 0; b < 4; b++)
         if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_w[k] = w;
   endtask

   function automatic int halves_of(input bit wr, input logic [3:0] m);
      if (!wr) return 2;
      return int'(|m[1:0]) + int'(|m[3:2]);
   endfunction

   function automatic int exp_lat(input bit wr, input logic [3:0] m);
      return halves_of(wr, m) * (WC + 3) + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] m, input string tag);
      int n, we_lo, ce_lo, k, h;
      bit seen;
      k = int'(a[AW-2:0]);
      h = halves_of(1'b1, m);
      @(posedge cpu_clk2); #1;
      mem_address = a; mem_wr_data = d; mem_wr_mask = m;
      mem_wr_enable = 1'b1;
      @(posedge cpu_clk2);
      n = 1; we_lo = 0; ce_lo = 0; seen = 0;
      while (n < 200) begin
         @(negedge cpu_clk2);
         if (mem_wr_ack) begin seen = 1; break; end
         if (!sram_we_n) begin
            we_lo++;
            last_ub = sram_ub_n;
            last_lb = sram_lb_n;
         end
         if (!sram_ce_n) ce_lo++;
         @(posedge cpu_clk2);
         n++;
      end
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
      chk({tag, "_lat"}, n, exp_lat(1'b1, m));
      chk({tag, "_we_cycles"}, we_lo, h * (WC + 1));
      chk({tag, "_ce_cycles"}, ce_lo, h * (WC + 3));
      @(posedge cpu_clk2); #1;
      mem_wr_enable = 1'b0;
      @(negedge cpu_clk2);
      chk({tag, "_ack_width"}, 32'(mem_wr_ack), 32'd0);
      ref_write(k, d, m);
      chk({tag, "_sram_lo"}, 32'(hw_rd(2*k)), 32'(exp_word(k) & 32'hFFFF));
      chk({tag, "_sram_hi"}, 32'(hw_rd(2*k+1)), 32'(exp_word(k) >> 16));
   endtask

   task automatic do_read(input logic [29:0] a, input string tag);
      int n, k;
      bit seen;
      logic [31:0] got;
      k = int'(a[AW-2:0]);
      @(posedge cpu_clk2); #1;
      mem_address = a;
      mem_rd_enable = 1'b1;
      @(posedge cpu_clk2);
      n = 1; seen = 0;
      while (n < 200) begin
         @(negedge cpu_clk2);
         if (mem_rd_valid) begin seen = 1; break; end
         @(posedge cpu_clk2);
         n++;
      end
      got = mem_rd_data;
      chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
      chk({tag, "_lat"}, n, exp_lat(1'b0, 4'h0));
      chk({tag, "_data"}, got, exp_word(k));
      @(posedge cpu_clk2); #1;
      mem_rd_enable = 1'b0;
      @(negedge cpu_clk2);
      chk({tag, "_valid_width"}, 32'(mem_rd_valid), 32'd0);
      chk({tag, "_data_stable"}, mem_rd_data, got);
   endtask

   initial begin
      int acks, vals, ack_i, val_i, seen_oe, late_vals;
      logic [31:0] sim_rd;
      logic [29:0] ra;
      logic [31:0] rd;
      logic [3:0]  rm;

      #3;
      chk("rst_strobes",
          {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
          32'h1F);
      chk("rst_addr", 32'(sram_a), 32'd0);
      chk("rst_ack", 32'(mem_wr_ack), 32'd0);
      chk("rst_valid", 32'(mem_rd_valid), 32'd0);
      chk("rst_rd_data", mem_rd_data, 32'd0);
      @(posedge cpu_clk2); @(posedge cpu_clk2); #1;
      rst = 1'b0;

      do_write(30'h10, 32'h11223344, 4'hF, "wr_full");
      chk("wr_full_hw20", 32'(hw_rd(32'h20)), 32'h3344);
      chk("wr_full_hw21", 32'(hw_rd(32'h21)), 32'h1122);

      do_read(30'h10, "rd_full");
      chk("rd_full_const", mem_rd_data, 32'h11223344);

      do_write(30'h10, 32'hAABBCCDD, 4'b0100, "wr_b2");
      chk("wr_b2_ub", 32'(last_ub), 32'd1);
      chk("wr_b2_lb", 32'(last_lb), 32'd0);
      chk("wr_b2_hw21", 32'(hw_rd(32'h21)), 32'h11BB);
      chk("wr_b2_hw20", 32'(hw_rd(32'h20)), 32'h3344);

      do_write(30'h10, 32'hDEADBEEF, 4'b0000, "wr_none");
      do_read(30'h10, "rd_after_none");

      // Simultaneous write and read, both levels held past their pulses
      @(posedge cpu_clk2); #1;
      mem_address = 30'h20; mem_wr_data = 32'hCAFEF00D;
      mem_wr_mask = 4'hF;
      mem_wr_enable = 1'b1; mem_rd_enable = 1'b1;
      ref_write(32'h20, 32'hCAFEF00D, 4'hF);
      acks = 0; vals = 0; ack_i = -1; val_i = -1; sim_rd = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge cpu_clk2);
         if (mem_wr_ack) begin acks++; ack_i = i; end
         if (mem_rd_valid) begin
            vals++; val_i = i; sim_rd = mem_rd_data;
         end
      end
      chk("sim_ack_count", acks, 1);
      chk("sim_valid_count", vals, 1);
      chk("sim_order_gap", val_i - ack_i, 12);
      chk("sim_rd_data", sim_rd, exp_word(32'h20));
      @(posedge cpu_clk2); #1;
      mem_wr_enable = 1'b0; mem_rd_enable = 1'b0;

      // Reset asserted in the middle of a read strobe
      @(posedge cpu_clk2); #1;
      mem_address = 30'h10;
      mem_rd_enable = 1'b1;
      seen_oe = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge cpu_clk2);
         if (!sram_oe_n) seen_oe++;
         if (seen_oe == 2) break;
      end
      chk("abort_in_strobe", seen_oe, 2);
      #2;
      rst = 1'b1;
      mem_rd_enable = 1'b0;
      #1;
      chk("abort_strobes",
          {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
          32'h1F);
      chk("abort_addr", 32'(sram_a), 32'd0);
      chk("abort_valid", 32'(mem_rd_valid), 32'd0);
      chk("abort_rd_data", mem_rd_data, 32'd0);
      @(posedge cpu_clk2); @(posedge cpu_clk2); #1;
      rst = 1'b0;
      late_vals = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge cpu_clk2);
         if (mem_rd_valid) late_vals++;
      end
      chk("abort_no_valid", late_vals, 0);
      do_read(30'h10, "rd_after_abort");

      // Random traffic, with aliasing through ignored upper address bits
      for (int i = 0; i < 40; i++) begin
         ra = {11'($urandom), 19'($urandom_range(0, 15))};
         rd = $urandom;
         rm = 4'($urandom);
         if ($urandom_range(0, 1) == 1)
            do_write(ra, rd, rm, "rnd_wr");
         else
            do_read(ra, "rnd_rd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_mem_target.md
Name: sram_mem_target

Overview:
- Memory-bus target: the responder end of the mem_* request/response bus driven by the CPU bus bridge.
- Serves 32-bit word read and write requests from an external asynchronous 16-bit SRAM.
- Each word is split into two halfword SRAM accesses, with programmable wait states.
- Generates the mem_rd_valid and mem_wr_ack responses that release the CPU bus cycle.

Parameters:
ADDR_WIDTH, 20, highest SRAM address bit; SRAM halfword address is sram_a[ADDR_WIDTH:1].
WAIT_CYCLES, 2, extra strobe cycles per halfword access (0..15); strobe width = WAIT_CYCLES+1 cycles.

Ports:
cpu_clk2  in  1  clock (2x CPU clock)
rst  in  1  reset, asynchronous, active-high
mem_address  in  30  word address [31:2]; bits above ADDR_WIDTH ignored (aliasing)
mem_wr_data  in  32  write data
mem_wr_mask  in  4  byte enables for write, bit n = byte n
mem_wr_enable  in  1  write request, level, held until mem_wr_ack
mem_wr_ack  out  1  one-cycle write-complete pulse
mem_rd_enable  in  1  read request, level, held until mem_rd_valid
mem_rd_data  out  32  read data, stable from mem_rd_valid until next read completes
mem_rd_valid  out  1  one-cycle read-complete pulse
sram_a  out  ADDR_WIDTH  halfword address [ADDR_WIDTH:1]
sram_dq  inout  16  SRAM data
sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (async):
  - State is IDLE.
  - mem_wr_ack=0, mem_rd_valid=0, mem_rd_data=0.
  - All sram_*_n=1, sram_a=0, sram_dq tri-stated.
  - rd_armed=wr_armed=1.
  - Reset asserted mid-access aborts immediately with the same values; no response is issued.
- Arming:
  - wr_armed is set in any cycle mem_wr_enable=0; rd_armed likewise for mem_rd_enable.
  - Each flag is cleared when its request is accepted.
  - A level held high after its response is therefore never re-served.
- Acceptance (IDLE only):
  - Write priority: accept a write if mem_wr_enable&wr_armed, otherwise accept a read if mem_rd_enable&rd_armed.
  - On acceptance, register the address, data, mask and op.
  - A simultaneous read stays pending and is served after the write completes.
- Half selection:
  - Read: low half (sram_a[1]=0) then high half; ub_n=lb_n=0 for both.
  - Write: a half is skipped if its two mask bits are 0.
  - Write lb_n=~mask[0]/~mask[2] and ub_n=~mask[1]/~mask[3] for the low/high half.
  - Write low half data = wr_data[15:0], high half data = wr_data[31:16].
- State machine: IDLE -> SETUP -> STROBE -> HOLD -> (SETUP for next half | RESP) -> IDLE.
  - SETUP (1 cycle):
    - ce_n=0, address valid.
    - Read: oe_n=0.
    - Write: dq driven, we_n=1.
  - STROBE (WAIT_CYCLES+1 cycles, 4-bit down-counter):
    - Read: oe_n=0; sram_dq is sampled into the matching mem_rd_data half at the final STROBE edge.
    - Write: we_n=0.
  - HOLD (1 cycle):
    - ce_n=0, oe_n=1, we_n=1.
    - Write: dq still driven.
  - RESP (1 cycle): mem_rd_valid or mem_wr_ack = 1, all strobes inactive, dq tri-stated.
- sram_dq is driven only in write SETUP/STROBE/HOLD; never driven when oe_n=0.
- A write with mask 0000 goes IDLE -> RESP; ack is high in the cycle after acceptance.
- Latency:
  - Measured from the accepting edge to the pulse cycle.
  - Per half: WAIT_CYCLES+3 cycles.
  - Read: 2*(WAIT_CYCLES+3)+1.
  - Single-half write: (WAIT_CYCLES+3)+1.
  - WAIT_CYCLES=2 gives 11 and 6 cycles.
- Back-to-back: the next request may be accepted in the IDLE cycle immediately after RESP.
- mem_rd_data is not modified by writes or aborted reads.

Test Plan:
- Write addr 0x00010, data 0x11223344, mask 1111, WAIT=2 -> SRAM halfwords 0x20 = 0x3344 and 0x21 = 0x1122; we_n low 3 cycles each; ack 11 cycles after accept, 1 cycle wide.
- Read back the same address -> mem_rd_data = 0x11223344, rd_valid 1 cycle, 11 cycles after accept; dq never driven during the read.
- Write mask 0100, data 0xAABBCCDD -> only the high half is accessed, ub_n=1, lb_n=0, byte 2 = 0xBB; other bytes unchanged; ack after 6 cycles.
- Write mask 0000 -> no ce_n activity, ack 1 cycle after accept.
- rd_enable and wr_enable raised together, both held high after their pulses -> write served first, then read; exactly one ack and one valid, no repeats until each enable drops.
- Assert rst during a read's STROBE -> strobes go inactive immediately and no rd_valid; after release, a fresh read completes normally.
